// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised modulo counter.
package counter_pkg;

  localparam logic CNT_DOWN = 1'b0;
  localparam logic CNT_UP   = 1'b1;

  localparam logic CNT_WRAP = 1'b0;
  localparam logic CNT_SAT  = 1'b1;

  // Bits needed to hold 0..v-1; never less than one so a PRESCALE of 1 still has a register.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Divides enabled cycles by PRESCALE; step pulses combinationally on the last tick of each period.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int CW = clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  assign step = en && (cnt_reg == LAST);

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = step ? '0 : cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/mod_counter_param.sv
// Up/down modulo counter with load, wrap/saturate, terminal-count pulse and sticky overflow.
// Define COUNTER_PRESCALE_EN to insert a PRESCALE-cycle prescaler ahead of each count step.
module mod_counter_param
  import counter_pkg::*;
#(
  parameter int     WIDTH    = 7,
  parameter longint MODULUS  = 100,
  parameter int     PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

  if (WIDTH < 2 || WIDTH > 32 || MODULUS < 2 || MODULUS > (64'sd1 <<< WIDTH) || PRESCALE < 1)
  begin : g_param_err
    $error("mod_counter_param: illegal WIDTH/MODULUS/PRESCALE combination");
  end

  logic             step;
  logic [WIDTH-1:0] q_reg, q_next;
  logic             tc_reg, tc_next;
  logic             ovf_reg, ovf_next;
  logic             at_bound;

`ifdef COUNTER_PRESCALE_EN
  counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .clr  (load),
    .step (step)
  );
`else
  assign step = en;
`endif

  assign at_bound = (up_dn == CNT_UP) ? (q_reg == MAXV) : (q_reg == '0);

  always_comb begin
    q_next   = q_reg;
    tc_next  = 1'b0;
    ovf_next = ovf_reg & ~clr_ovf;
    if (load) begin
      q_next = (load_val > MAXV) ? MAXV : load_val;
    end else if (step) begin
      if (at_bound) begin
        // Set beats a simultaneous clr_ovf.
        tc_next  = 1'b1;
        ovf_next = 1'b1;
        if (sat == CNT_WRAP) begin
          q_next = (up_dn == CNT_UP) ? '0 : MAXV;
        end
      end else begin
        q_next = (up_dn == CNT_UP) ? q_reg + WIDTH'(1) : q_reg - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg   <= '0;
      tc_reg  <= 1'b0;
      ovf_reg <= 1'b0;
    end else begin
      q_reg   <= q_next;
      tc_reg  <= tc_next;
      ovf_reg <= ovf_next;
    end
  end

  assign q   = q_reg;
  assign tc  = tc_reg;
  assign ovf = ovf_reg;

endmodule

// File: tb/tb_mod_counter_param.sv
// Directed bench for mod_counter_param (WIDTH=7, MODULUS=100, PRESCALE=4).
// Build with COUNTER_PRESCALE_EN to exercise the prescaler vectors instead of the plain count vectors.
module tb_mod_counter_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, up_dn, sat, load, clr_ovf;
  logic [6:0] load_val;
  logic [6:0] q;
  logic       tc, ovf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mod_counter_param #(
    .WIDTH(7),
    .MODULUS(100),
    .PRESCALE(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .up_dn   (up_dn),
    .sat     (sat),
    .load    (load),
    .load_val(load_val),
    .clr_ovf (clr_ovf),
    .q       (q),
    .tc      (tc),
    .ovf     (ovf)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int eq, input int etc, input int eovf);
    check_val({tag, ".q"}, 32'(q), 32'(eq));
    check_val({tag, ".tc"}, 32'(tc), 32'(etc));
    check_val({tag, ".ovf"}, 32'(ovf), 32'(eovf));
  endtask

  task automatic do_load(input int v);
    load = 1'b1; load_val = 7'(v);
    tick();
    load = 1'b0;
  endtask

`ifndef COUNTER_PRESCALE_EN
  int exp_q [5];
  int exp_tc[5];
`endif

  initial begin
    reset = 1'b0; en = 1'b1; up_dn = 1'b1; sat = 1'b0;
    load = 1'b0; load_val = '0; clr_ovf = 1'b0;

    // Reset held for two edges with en high.
    tick(); tick();
    check_out("reset_hold", 0, 0, 0);
    #2 reset = 1'b1; en = 1'b0;
    tick();
    check_out("reset_release", 0, 0, 0);

    // Load clamp and priority over en.
    en = 1'b1;
    do_load(120);
    check_out("load_clamp", 99, 0, 0);
    do_load(5);
    check_out("load_5", 5, 0, 0);
    en = 1'b0;

`ifndef COUNTER_PRESCALE_EN
    // Up wrap.
    sat = 1'b0; up_dn = 1'b1;
    do_load(97);
    check_out("wrap_load", 97, 0, 0);
    en = 1'b1;
    exp_q  = '{98, 99, 0, 1, 1};
    exp_tc = '{0, 0, 1, 0, 0};
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out($sformatf("wrap_%0d", i), exp_q[i], exp_tc[i], (i >= 2) ? 1 : 0);
    end
    en = 1'b0;
    tick();
    check_out("wrap_idle", 1, 0, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check_out("clr_ovf", 1, 0, 0);

    // Down saturate.
    sat = 1'b1; up_dn = 1'b0;
    do_load(2);
    en = 1'b1;
    exp_q  = '{1, 0, 0, 0, 0};
    exp_tc = '{0, 0, 1, 1, 1};
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out($sformatf("dsat_%0d", i), exp_q[i], exp_tc[i], (i >= 2) ? 1 : 0);
    end
    en = 1'b0;

    // Load leaves ovf untouched.
    do_load(50);
    check_out("load_keeps_ovf", 50, 0, 1);

    // Boundary event beats simultaneous clr_ovf.
    clr_ovf = 1'b1;
    do_load(99);
    check_out("pre_race", 99, 0, 0);
    sat = 1'b0; up_dn = 1'b1; en = 1'b1;
    tick();
    check_out("race", 0, 1, 1);
    clr_ovf = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("hold_%0d", i), 0, 0, 1);
    end

    // Mid-count asynchronous reset.
    do_load(30);
    en = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check_out("count_to_37", 37, 0, 1);
    reset = 1'b0;
    #1;
    check_out("async_reset", 0, 0, 0);
    #2 reset = 1'b1;
    tick();
    check_out("after_reset", 1, 0, 0);
    en = 1'b0;
`else
    // Prescaled counting from 0.
    sat = 1'b0; up_dn = 1'b1;
    do_load(0);
    en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check_val($sformatf("ps_%0d", i), 32'(q), 32'(i / 4));
      check_val($sformatf("ps_tc_%0d", i), 32'(tc), 32'd0);
    end
    // Gap of two en-low cycles mid-period stretches it by two.
    tick(); tick();
    check_val("ps_mid", 32'(q), 32'd3);
    en = 1'b0;
    tick(); tick();
    check_val("ps_frozen", 32'(q), 32'd3);
    en = 1'b1;
    tick();
    check_val("ps_resume1", 32'(q), 32'd3);
    tick();
    check_val("ps_resume2", 32'(q), 32'd4);
    // Load mid-period restarts the prescaler.
    tick(); tick();
    load = 1'b1; load_val = 7'd10;
    tick();
    load = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_val($sformatf("ps_reload_%0d", i), 32'(q), (i == 4) ? 32'd11 : 32'd10);
    end
    en = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mod_counter_param.md
Name: mod_counter_param

Overview:
- Parametrised up/down modulo counter; next generation of the team's fixed 7-bit free-running counter.
- Adds:
  - configurable width and modulus
  - count enable, direction, synchronous load
  - wrap or saturate mode
  - registered terminal-count pulse and sticky overflow flag
- Used as a timebase, event counter or sequence index in synchronous datapaths.

Parameters:
- WIDTH, 7, counter width in bits; legal range 2..32.
- MODULUS, 100, count range is 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH.
- PRESCALE, 4, enabled ticks per count step; legal minimum 1; used only with COUNTER_PRESCALE_EN.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset; asserted while 0.
- en  input  1  count enable.
- up_dn  input  1  1 = count up, 0 = count down.
- sat  input  1  0 = wrap mode, 1 = saturate mode.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value to load.
- clr_ovf  input  1  clears the sticky overflow flag.
- q  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered.
- ovf  output  1  sticky overflow/saturation flag.

Behaviour:
- Reset: while reset=0, immediately force q=0, tc=0, ovf=0 (and prescaler=0), independent of clk. Mid-count assertion aborts the count; the first edge after release counts normally.
- Priority per edge: load > en. With en=0 and load=0, q holds and tc=0.
- Load:
  - q <= load_val if load_val < MODULUS; otherwise q <= MODULUS-1 (clamp).
  - tc=0 on the following cycle; ovf unchanged. Load also clears the prescaler.
- Count step (en=1, no load, step permitted):
  - Up, q < MODULUS-1: q+1.
  - Down, q > 0: q-1.
- Boundary events (up at MODULUS-1, or down at 0):
  - sat=0: up wraps to 0; down wraps to MODULUS-1.
  - sat=1: q holds.
  - Either mode: tc=1 and ovf set.
- tc:
  - High for exactly one cycle, in the cycle after the boundary edge (same cycle q shows the wrapped/held value).
  - In sat mode, tc re-pulses on every enabled step attempted at the boundary.
- ovf:
  - Set by any boundary event; cleared by clr_ovf=1 at an edge.
  - Simultaneous set and clr_ovf: set wins.
- Arithmetic:
  - No intermediate value ever leaves 0..MODULUS-1.
  - Comparisons are done at WIDTH bits; MODULUS-1 is a WIDTH-bit constant.
- Direction or mode may change on any cycle; the new value applies at that edge.
- Latency: q updates one edge after the qualifying input; outputs are fully registered.

Optional Feature:
- Macro: COUNTER_PRESCALE_EN.
- Defined:
  - Internal prescaler counts en-high cycles 0..PRESCALE-1.
  - A count step occurs only on the edge where the prescaler is at PRESCALE-1; the prescaler then returns to 0.
  - en=0 freezes the prescaler. PRESCALE=1 behaves as undefined.
- Undefined: every en-high edge is a count step; the PRESCALE parameter is ignored; no prescaler logic is synthesised.

Decomposition:
- Package counter_pkg:
  - direction constants CNT_DOWN=0, CNT_UP=1
  - mode constants CNT_WRAP=0, CNT_SAT=1
  - function clog2 for the prescaler width
- Sub-module counter_prescaler (params PRESCALE; ports clk, reset, en, clr, step):
  - instantiated only under COUNTER_PRESCALE_EN
  - step is a combinational pulse qualifying the main counter

Test Plan:
- Reset: hold reset=0 for 2 cycles with en=1, then release -> q=0, tc=0, ovf=0; assert reset=0 mid-count at q=37 -> q=0 immediately, before any clk edge.
- Up wrap (MODULUS=100, sat=0, up_dn=1): load 97, then en=1 for 4 cycles -> q=98,99,0,1; tc=1 only in the cycle q=0; ovf=1 and stays 1 until clr_ovf pulse, then ovf=0.
- Down saturate (sat=1, up_dn=0): load 2, then en=1 for 5 cycles -> q=1,0,0,0,0; tc=1 in each of the last three cycles; ovf=1.
- Load priority and clamp: load=1 with en=1, load_val=120 -> q=99, tc=0; load_val=5 -> q=5.
- Simultaneous clr_ovf with a boundary event (up at q=99, clr_ovf=1) -> ovf=1 after the edge; en=0 for 3 cycles -> q and ovf hold, tc=0.
- COUNTER_PRESCALE_EN with PRESCALE=4: en=1 for 12 cycles from q=0 -> q increments once every 4 cycles, reaching 3; drop en for 2 cycles mid-period -> period extends by 2; load mid-period -> prescaler restarts from 0.
